// File: rtl/io_responder_pkg.sv
// io_responder_pkg
// Shared definitions for the CPU I/O responder: register select codes,
// status bit positions, the I/O region address tag and a helper that packs
// the status byte.
package io_responder_pkg;

  // Value of the two address bits just above the RAM range that mark an I/O access.
  localparam logic [1:0] IO_REGION_TAG = 2'b11;

  // Register selects (a[2:0]).
  localparam logic [2:0] IO_SEL_DATA   = 3'd0;
  localparam logic [2:0] IO_SEL_STATUS = 3'd1;
  localparam logic [2:0] IO_SEL_HALT   = 3'd3;
  localparam logic [2:0] IO_SEL_CNT0   = 3'd4;
  localparam logic [2:0] IO_SEL_CNT1   = 3'd5;
  localparam logic [2:0] IO_SEL_CNT2   = 3'd6;
  localparam logic [2:0] IO_SEL_CNT3   = 3'd7;

  // Status byte bit positions.
  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_OVERFLOW = 2;

  function automatic logic [7:0] status_byte(input logic tx_full, input logic rx_full,
                                             input logic overflow);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_TX_FULL]  = tx_full;
    s[STAT_RX_FULL]  = rx_full;
    s[STAT_OVERFLOW] = overflow;
    return s;
  endfunction

endpackage

// File: rtl/io_responder_tx_fifo.sv
// io_tx_fifo
// Parameterised synchronous circular-buffer FIFO with simultaneous push/pop.
// A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
// Ports:
//   clk_i, rst_n_i   clock, synchronous active-low reset
//   push_i, data_i   write strobe and data
//   pop_i            read strobe (head advances)
//   data_o           head entry (combinational from storage)
//   full_o, empty_o  occupancy flags
//   count_o          number of stored entries (0 .. 2^DEPTH_LOG2)
module io_tx_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q,  count_d;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_CNT);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: every variable assigned in a combinational block gets a default
  // first, otherwise a path that skips it infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is cleared on reset (not just the pointers) so the head
  // output reads zero after reset instead of stale or unknown data.
  // Sequential state uses non-blocking assignments throughout.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/io_responder.sv
// io_responder
// Responder for the I/O region of the CPU byte-wide memory bus. Sits beside
// the synchronous RAM; read data is registered so read timing matches RAM.
//   sel 0  W: push TX FIFO        R: pop RX holding register (0 if empty)
//   sel 1  R: status {5'b0, overflow, rx_full, tx_full}
//   sel 3  W: halt with exit code (first write only)
//   sel 4  R: snapshot cycle counter, return bits [7:0]
//   sel 5-7 R: snapshot bits [15:8], [23:16], [31:24]
// Ports:
//   clk_in, rst_n_in       clock, synchronous active-low reset
//   rdy_in                 bus enable; low ignores accesses and freezes counter
//   a_in, wr_in, d_in      bus address, write strobe, write data
//   d_out                  registered read data
//   tx_data_out/valid_out/ready_in   byte output stream (head of TX FIFO)
//   rx_data_in/valid_in/ready_out    byte input stream (RX holding register)
//   halt_out, halt_code_out          sticky program-end flag and exit code
module io_responder
  import io_responder_pkg::*;
#(
  parameter int ADDR_WIDTH      = 17,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [31:0] a_in,
  input  logic        wr_in,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid_in,
  output logic        rx_ready_out,
  output logic        halt_out,
  output logic [7:0]  halt_code_out
);

  logic       acc, rd_acc, wr_acc;
  logic [2:0] sel;
  logic       unused_addr;

  logic                     tx_push, tx_pop, tx_full, tx_empty;
  logic [FIFO_DEPTH_LOG2:0] tx_count;

  logic [7:0]  d_out_q,     d_out_d;
  logic [7:0]  rx_data_q,   rx_data_d;
  logic        rx_full_q,   rx_full_d;
  logic        overflow_q,  overflow_d;
  logic        halt_q,      halt_d;
  logic [7:0]  halt_code_q, halt_code_d;
  logic [31:0] cnt_q,       cnt_d;
  logic [31:0] snap_q,      snap_d;

  assign acc    = rdy_in && (a_in[ADDR_WIDTH:ADDR_WIDTH-1] == IO_REGION_TAG);
  assign sel    = a_in[2:0];
  assign rd_acc = acc && !wr_in;
  assign wr_acc = acc && wr_in;

  // Address bits outside the region tag and the select field are don't-care.
  assign unused_addr = ^{a_in[31:ADDR_WIDTH+1], a_in[ADDR_WIDTH-2:3]};

  assign tx_push = wr_acc && (sel == IO_SEL_DATA);
  assign tx_pop  = tx_ready_in && !tx_empty;

  io_tx_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .push_i  (tx_push),
    .data_i  (d_in),
    .pop_i   (tx_pop),
    .data_o  (tx_data_out),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  always_comb begin
    d_out_d     = d_out_q;
    rx_data_d   = rx_data_q;
    rx_full_d   = rx_full_q;
    overflow_d  = overflow_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    cnt_d       = cnt_q;
    snap_d      = snap_q;

    if (rdy_in) cnt_d = cnt_q + 32'd1;

    if (rd_acc) begin
      case (sel)
        IO_SEL_DATA: begin
          d_out_d   = rx_full_q ? rx_data_q : 8'h00;
          rx_full_d = 1'b0;
        end
        IO_SEL_STATUS: d_out_d = status_byte(tx_full, rx_full_q, overflow_q);
        IO_SEL_CNT0: begin
          d_out_d = cnt_q[7:0];
          snap_d  = cnt_q;
        end
        IO_SEL_CNT1: d_out_d = snap_q[15:8];
        IO_SEL_CNT2: d_out_d = snap_q[23:16];
        IO_SEL_CNT3: d_out_d = snap_q[31:24];
        default:     d_out_d = 8'h00;
      endcase
    end

    if (wr_acc && (sel == IO_SEL_HALT) && !halt_q) begin
      halt_d      = 1'b1;
      halt_code_d = d_in;
    end

    // A full FIFO still accepts a push when the sink pops in the same cycle.
    if (tx_push && tx_full && !tx_pop) overflow_d = 1'b1;

    // Load comes after the read-clear: a same-cycle read sees the old
    // contents while the new byte is retained.
    if (rx_valid_in && !rx_full_q) begin
      rx_full_d = 1'b1;
      rx_data_d = rx_data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      d_out_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_full_q   <= 1'b0;
      overflow_q  <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= 8'h00;
      cnt_q       <= 32'h0;
      snap_q      <= 32'h0;
    end else begin
      d_out_q     <= d_out_d;
      rx_data_q   <= rx_data_d;
      rx_full_q   <= rx_full_d;
      overflow_q  <= overflow_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
    end
  end

  assign d_out         = d_out_q;
  assign rx_ready_out  = !rx_full_q;
  assign tx_valid_out  = (tx_count != '0);
  assign halt_out      = halt_q;
  assign halt_code_out = halt_code_q;

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder
// Directed self-checking bench for io_responder. Inputs are driven 1 time
// unit after the rising edge; outputs are sampled at that same point.
module tb_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic [31:0] a_in;
  logic        wr_in;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic [7:0]  rx_data_in;
  logic        rx_valid_in;
  logic        rx_ready_out;
  logic        halt_out;
  logic [7:0]  halt_code_out;

  int passed = 0;
  int total  = 0;

  io_responder dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rdy_in        (rdy_in),
    .a_in          (a_in),
    .wr_in         (wr_in),
    .d_in          (d_in),
    .d_out         (d_out),
    .tx_data_out   (tx_data_out),
    .tx_valid_out  (tx_valid_out),
    .tx_ready_in   (tx_ready_in),
    .rx_data_in    (rx_data_in),
    .rx_valid_in   (rx_valid_in),
    .rx_ready_out  (rx_ready_out),
    .halt_out      (halt_out),
    .halt_code_out (halt_code_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_reset;
    wr_in       = 1'b0;
    a_in        = 32'h0;
    tx_ready_in = 1'b0;
    rx_valid_in = 1'b0;
    rdy_in      = 1'b1;
    rst_n_in    = 1'b0;
    tick();
    rst_n_in    = 1'b1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [7:0] data);
    rdy_in = 1'b1;
    a_in   = addr;
    wr_in  = 1'b1;
    d_in   = data;
    tick();
    wr_in  = 1'b0;
    a_in   = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [7:0] data);
    rdy_in = 1'b1;
    a_in   = addr;
    wr_in  = 1'b0;
    tick();
    a_in   = 32'h0;
    data   = d_out;
  endtask

  task automatic rx_pulse(input logic [7:0] data);
    rx_data_in  = data;
    rx_valid_in = 1'b1;
    tick();
    rx_valid_in = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    apply_reset();
    total++; if (d_out !== 8'h00) $display("FAIL reset_d_out: got %h want 00", d_out); else passed++;
    total++; if (tx_valid_out !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid_out); else passed++;
    total++; if (tx_data_out !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data_out); else passed++;
    total++; if (rx_ready_out !== 1'b1) $display("FAIL reset_rx_ready: got %b want 1", rx_ready_out); else passed++;
    total++; if (halt_out !== 1'b0) $display("FAIL reset_halt: got %b want 0", halt_out); else passed++;
    bus_read(32'h30001, v);
    total++; if (v !== 8'h00) $display("FAIL reset_status: got %h want 00", v); else passed++;
  endtask

  task automatic test_tx_order;
    apply_reset();
    bus_write(32'h30000, 8'h41);
    bus_write(32'h30000, 8'h42);
    bus_write(32'h30000, 8'h43);
    total++; if (tx_valid_out !== 1'b1) $display("FAIL tx_valid_filled: got %b want 1", tx_valid_out); else passed++;
    tx_ready_in = 1'b1;
    total++; if (tx_data_out !== 8'h41) $display("FAIL tx_first: got %h want 41", tx_data_out); else passed++;
    tick();
    total++; if (tx_data_out !== 8'h42) $display("FAIL tx_second: got %h want 42", tx_data_out); else passed++;
    tick();
    total++; if (tx_data_out !== 8'h43) $display("FAIL tx_third: got %h want 43", tx_data_out); else passed++;
    tick();
    total++; if (tx_valid_out !== 1'b0) $display("FAIL tx_drained: got %b want 0", tx_valid_out); else passed++;
    tx_ready_in = 1'b0;
  endtask

  task automatic test_overflow;
    logic [7:0] v;
    logic [7:0] exp_q [16];
    apply_reset();
    for (int i = 0; i < 17; i++) bus_write(32'h30000, 8'(8'h10 + i));
    bus_read(32'h30001, v);
    total++; if (v !== 8'h05) $display("FAIL ovf_status: got %h want 05", v); else passed++;
    // Push while full with a simultaneous pop: 0x10 leaves, 0x77 enters.
    tx_ready_in = 1'b1;
    bus_write(32'h30000, 8'h77);
    tx_ready_in = 1'b0;
    bus_read(32'h30001, v);
    total++; if (v !== 8'h05) $display("FAIL full_push_pop_status: got %h want 05", v); else passed++;
    for (int i = 0; i < 15; i++) exp_q[i] = 8'(8'h11 + i);
    exp_q[15] = 8'h77;
    tx_ready_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (tx_valid_out !== 1'b1 || tx_data_out !== exp_q[i])
        $display("FAIL drain_%0d: got valid=%b data=%h want valid=1 data=%h", i, tx_valid_out, tx_data_out, exp_q[i]);
      else passed++;
      tick();
    end
    total++; if (tx_valid_out !== 1'b0) $display("FAIL drain_empty: got %b want 0", tx_valid_out); else passed++;
    tx_ready_in = 1'b0;
  endtask

  task automatic test_back_to_back;
    apply_reset();
    tx_ready_in = 1'b1;
    bus_write(32'h30000, 8'h55);
    total++; if (tx_valid_out !== 1'b1 || tx_data_out !== 8'h55) $display("FAIL b2b_first: got valid=%b data=%h want 1/55", tx_valid_out, tx_data_out); else passed++;
    bus_write(32'h30000, 8'h66);
    total++; if (tx_valid_out !== 1'b1 || tx_data_out !== 8'h66) $display("FAIL b2b_second: got valid=%b data=%h want 1/66", tx_valid_out, tx_data_out); else passed++;
    tick();
    total++; if (tx_valid_out !== 1'b0) $display("FAIL b2b_empty: got %b want 0", tx_valid_out); else passed++;
    tx_ready_in = 1'b0;
  endtask

  task automatic test_rx;
    logic [7:0] v;
    apply_reset();
    rx_pulse(8'h5A);
    total++; if (rx_ready_out !== 1'b0) $display("FAIL rx_loaded_ready: got %b want 0", rx_ready_out); else passed++;
    bus_read(32'h30001, v);
    total++; if (v !== 8'h02) $display("FAIL rx_status: got %h want 02", v); else passed++;
    bus_read(32'h30000, v);
    total++; if (v !== 8'h5A) $display("FAIL rx_read: got %h want 5a", v); else passed++;
    total++; if (rx_ready_out !== 1'b1) $display("FAIL rx_cleared_ready: got %b want 1", rx_ready_out); else passed++;
    bus_read(32'h30000, v);
    total++; if (v !== 8'h00) $display("FAIL rx_empty_read: got %h want 00", v); else passed++;
    // Prime d_out with a non-zero value so the next result is meaningful.
    bus_read(32'h30004, v);
    // Load and read in the same cycle: read sees the old (empty) contents.
    rx_data_in  = 8'hC3;
    rx_valid_in = 1'b1;
    a_in        = 32'h30000;
    wr_in       = 1'b0;
    tick();
    rx_valid_in = 1'b0;
    a_in        = 32'h0;
    total++; if (d_out !== 8'h00) $display("FAIL rx_same_cycle_data: got %h want 00", d_out); else passed++;
    total++; if (rx_ready_out !== 1'b0) $display("FAIL rx_same_cycle_ready: got %b want 0", rx_ready_out); else passed++;
    bus_read(32'h30000, v);
    total++; if (v !== 8'hC3) $display("FAIL rx_same_cycle_kept: got %h want c3", v); else passed++;
  endtask

  task automatic test_counter;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] snap;
    apply_reset();
    // Counter is 0 after the reset edge and counts 300 enabled edges.
    repeat (300) @(posedge clk_in);
    #1;
    rdy_in = 1'b0;
    // Halt write while the bus is disabled must be ignored.
    a_in  = 32'h30003;
    wr_in = 1'b1;
    d_in  = 8'hEE;
    repeat (10) tick();
    wr_in = 1'b0;
    a_in  = 32'h0;
    total++; if (halt_out !== 1'b0) $display("FAIL rdy_low_halt_ignored: got %b want 0", halt_out); else passed++;
    bus_read(32'h30004, b0);
    bus_read(32'h30005, b1);
    bus_read(32'h30006, b2);
    bus_read(32'h30007, b3);
    snap = {b3, b2, b1, b0};
    total++; if (b0 !== 8'h2C) $display("FAIL cnt_byte0: got %h want 2c", b0); else passed++;
    total++; if (snap !== 32'd300) $display("FAIL cnt_snapshot: got %0d want 300", snap); else passed++;
  endtask

  task automatic test_halt;
    logic [7:0] v;
    apply_reset();
    bus_write(32'h30003, 8'h07);
    total++; if (halt_out !== 1'b1 || halt_code_out !== 8'h07) $display("FAIL halt_first: got %b/%h want 1/07", halt_out, halt_code_out); else passed++;
    bus_write(32'h30003, 8'h09);
    total++; if (halt_code_out !== 8'h07) $display("FAIL halt_sticky_code: got %h want 07", halt_code_out); else passed++;
    bus_write(32'h30000, 8'hAB);
    rx_pulse(8'h3C);
    bus_read(32'h30001, v);
    total++; if (v !== 8'h02) $display("FAIL halt_status_read: got %h want 02", v); else passed++;
    total++; if (tx_valid_out !== 1'b1 || tx_data_out !== 8'hAB) $display("FAIL halt_tx_pending: got %b/%h want 1/ab", tx_valid_out, tx_data_out); else passed++;
    apply_reset();
    total++; if (d_out !== 8'h00) $display("FAIL rst2_d_out: got %h want 00", d_out); else passed++;
    total++; if (tx_valid_out !== 1'b0 || tx_data_out !== 8'h00) $display("FAIL rst2_tx: got %b/%h want 0/00", tx_valid_out, tx_data_out); else passed++;
    total++; if (rx_ready_out !== 1'b1) $display("FAIL rst2_rx_ready: got %b want 1", rx_ready_out); else passed++;
    total++; if (halt_out !== 1'b0 || halt_code_out !== 8'h00) $display("FAIL rst2_halt: got %b/%h want 0/00", halt_out, halt_code_out); else passed++;
  endtask

  initial begin
    rst_n_in    = 1'b0;
    rdy_in      = 1'b1;
    a_in        = 32'h0;
    wr_in       = 1'b0;
    d_in        = 8'h00;
    tx_ready_in = 1'b0;
    rx_data_in  = 8'h00;
    rx_valid_in = 1'b0;
    test_reset();
    test_tx_order();
    test_overflow();
    test_back_to_back();
    test_rx();
    test_counter();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
